// File: rtl/decimation_sequencer.sv
// Decimation window controller: sequences the gated-clock/accumulator resets, captures one count
// per window and offers it on valid/ready. Define DEC_SEQ_OVF_CNT_EN to build the dropped-window counter.
module decimation_sequencer #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned RATIO_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [RATIO_W-1:0] ratio_i,
   input  logic [CNT_W-1:0]   count_in_i,
   output logic               gate_rst_o,
   output logic               acc_rst_o,
   output logic [CNT_W-1:0]   sample_data_o,
   output logic               sample_valid_o,
   input  logic               sample_ready_i,
   output logic               busy_o,
   output logic               overrun_o,
   output logic [7:0]         overrun_cnt_o
);

   typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

   state_e             state_q, state_d;
   logic [RATIO_W-1:0] n_q, n_d;
   logic [RATIO_W-1:0] wcnt_q, wcnt_d;
   logic               stop_pend_q, stop_pend_d;
   logic               gate_rst_q, gate_rst_d;
   logic               acc_rst_q, acc_rst_d;
   logic [CNT_W-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic               ovr_q, ovr_d;
   logic               win_end;
   logic               clr_ovr;

   // Window sequencing
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      wcnt_d      = wcnt_q;
      stop_pend_d = stop_pend_q;
      win_end     = 1'b0;
      clr_ovr     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               n_d         = (ratio_i == '0) ? RATIO_W'(1) : ratio_i;
               wcnt_d      = '0;
               stop_pend_d = 1'b0;
               clr_ovr     = 1'b1;
               state_d     = StRun;
            end
         end
         StRun: begin
            if (stop_i) stop_pend_d = 1'b1;
            if (wcnt_q == n_q) begin
               win_end = 1'b1;
               if (stop_pend_q || stop_i) begin
                  stop_pend_d = 1'b0;
                  state_d     = StIdle;
               end else begin
                  state_d = StFlush;
               end
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         StFlush: begin
            if (stop_i) stop_pend_d = 1'b1;
            wcnt_d  = '0;
            state_d = StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   // Holding register: a window ending while the consumer still holds the old sample is dropped
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q & ~clr_ovr;
      if (win_end) begin
         if (!valid_q || sample_ready_i) begin
            data_d  = count_in_i;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && sample_ready_i) begin
         valid_d = 1'b0;
      end
   end

   assign gate_rst_d = (state_d != StRun);
   assign acc_rst_d  = (state_d != StRun);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         n_q         <= RATIO_W'(1);
         wcnt_q      <= '0;
         stop_pend_q <= 1'b0;
         gate_rst_q  <= 1'b1;
         acc_rst_q   <= 1'b1;
         data_q      <= '0;
         valid_q     <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         wcnt_q      <= wcnt_d;
         stop_pend_q <= stop_pend_d;
         gate_rst_q  <= gate_rst_d;
         acc_rst_q   <= acc_rst_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ovr_q       <= ovr_d;
      end
   end

`ifdef DEC_SEQ_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;
   logic       drop;

   assign drop = win_end & valid_q & ~sample_ready_i;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (clr_ovr) begin
         ovf_cnt_d = '0;
      end else if (drop && (ovf_cnt_q != 8'hFF)) begin
         ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign overrun_cnt_o = ovf_cnt_q;
`else
   assign overrun_cnt_o = 8'h00;
`endif

   assign gate_rst_o     = gate_rst_q;
   assign acc_rst_o      = acc_rst_q;
   assign sample_data_o  = data_q;
   assign sample_valid_o = valid_q;
   assign overrun_o      = ovr_q;
   assign busy_o         = (state_q != StIdle) | stop_pend_q;

endmodule

// File: tb/tb_decimation_sequencer.sv
// Directed bench for decimation_sequencer with a behavioural gated-clock/accumulator front end.
module tb_decimation_sequencer;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned RATIO_W = 16;
`ifdef DEC_SEQ_OVF_CNT_EN
   localparam int unsigned ExpDrops = 2;
`else
   localparam int unsigned ExpDrops = 0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start_i = 1'b0;
   logic               stop_i = 1'b0;
   logic [RATIO_W-1:0] ratio_i = '0;
   logic [CNT_W-1:0]   count_in_i;
   logic               gate_rst_o;
   logic               acc_rst_o;
   logic [CNT_W-1:0]   sample_data_o;
   logic               sample_valid_o;
   logic               sample_ready_i = 1'b0;
   logic               busy_o;
   logic               overrun_o;
   logic [7:0]         overrun_cnt_o;

   logic               adc = 1'b0;
   logic [3:0]         pat = 4'b1111;
   int                 pat_idx = 0;
   logic [CNT_W-1:0]   acc_q;
   int                 n_vec = 0;
   int                 n_err = 0;
   int                 cyc;

   decimation_sequencer #(
      .CNT_W   (CNT_W),
      .RATIO_W (RATIO_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start_i        (start_i),
      .stop_i         (stop_i),
      .ratio_i        (ratio_i),
      .count_in_i     (count_in_i),
      .gate_rst_o     (gate_rst_o),
      .acc_rst_o      (acc_rst_o),
      .sample_data_o  (sample_data_o),
      .sample_valid_o (sample_valid_o),
      .sample_ready_i (sample_ready_i),
      .busy_o         (busy_o),
      .overrun_o      (overrun_o),
      .overrun_cnt_o  (overrun_cnt_o)
   );

   always #5 clk = ~clk;

   // Front end: ADC bit sampled on each edge is counted unless the accumulator is held in reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) acc_q <= '0;
      else if (acc_rst_o) acc_q <= '0;
      else acc_q <= acc_q + CNT_W'(adc);
   end
   assign count_in_i = acc_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      adc = pat[pat_idx % 4];
      pat_idx++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start_i = 1'b0;
      stop_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic do_start(input logic [RATIO_W-1:0] r);
      ratio_i = r;
      start_i = 1'b1;
      pat_idx = 0;
      step();
      start_i = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      while (cycles < budget) begin
         step();
         cycles++;
         if (sample_valid_o) break;
      end
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_gate", gate_rst_o, 1);
      chk("rst_acc", acc_rst_o, 1);
      chk("rst_valid", sample_valid_o, 0);
      chk("rst_data", sample_data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ovr", overrun_o, 0);
      chk("rst_ovr_cnt", overrun_cnt_o, 0);

      // ratio 8, ADC=1; a stop coinciding with start must be ignored
      pat = 4'b1111;
      sample_ready_i = 1'b1;
      stop_i = 1'b1;
      do_start(16'd8);
      stop_i = 1'b0;
      chk("r8_gate_low", gate_rst_o, 0);
      chk("r8_busy", busy_o, 1);
      wait_valid(20, cyc);
      chk("r8_lat1", cyc, 9);
      chk("r8_data1", sample_data_o, 8);
      chk("r8_flush_gate", gate_rst_o, 1);
      wait_valid(20, cyc);
      chk("r8_lat2", cyc, 10);
      chk("r8_data2", sample_data_o, 8);
      wait_valid(20, cyc);
      chk("r8_lat3", cyc, 10);

      // ratio 4, pattern 1,0,1,1; mid-run start with a new ratio is ignored
      do_reset();
      pat = 4'b1101;
      do_start(16'd4);
      wait_valid(20, cyc);
      chk("pat_lat1", cyc, 5);
      chk("pat_data1", sample_data_o, 3);
      ratio_i = 16'd9;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("pat_consumed", sample_valid_o, 0);
      wait_valid(20, cyc);
      chk("pat_lat2", cyc, 5);
      chk("pat_data2", sample_data_o, 3);
      wait_valid(20, cyc);
      chk("pat_lat3", cyc, 6);
      chk("pat_data3", sample_data_o, 3);

      // ratio 0 behaves as 1: samples follow the ADC bit 1,0,1,0
      do_reset();
      pat = 4'b0101;
      do_start(16'd0);
      wait_valid(20, cyc);
      chk("r0_lat1", cyc, 2);
      chk("r0_data1", sample_data_o, 1);
      wait_valid(20, cyc);
      chk("r0_lat2", cyc, 3);
      chk("r0_data2", sample_data_o, 0);
      wait_valid(20, cyc);
      chk("r0_data3", sample_data_o, 1);
      wait_valid(20, cyc);
      chk("r0_data4", sample_data_o, 0);

      // Back-pressure for three windows
      do_reset();
      pat = 4'b1111;
      sample_ready_i = 1'b0;
      do_start(16'd4);
      wait_valid(20, cyc);
      chk("bp_lat1", cyc, 5);
      repeat (12) step();
      chk("bp_valid", sample_valid_o, 1);
      chk("bp_data", sample_data_o, 4);
      chk("bp_ovr", overrun_o, 1);
      chk("bp_ovr_cnt", overrun_cnt_o, ExpDrops);
      sample_ready_i = 1'b1;
      step();
      chk("bp_drain", sample_valid_o, 0);
      wait_valid(20, cyc);
      chk("bp_lat_next", cyc, 5);
      chk("bp_data_next", sample_data_o, 4);
      chk("bp_ovr_sticky", overrun_o, 1);

      // Consume and capture on the same edge; held sample stable until then
      do_reset();
      pat = 4'b1111;
      sample_ready_i = 1'b0;
      do_start(16'd4);
      wait_valid(20, cyc);
      chk("sim_data1", sample_data_o, 4);
      pat = 4'b0000;
      repeat (5) step();
      chk("sim_hold_valid", sample_valid_o, 1);
      chk("sim_hold_data", sample_data_o, 4);
      sample_ready_i = 1'b1;
      step();
      chk("sim_valid", sample_valid_o, 1);
      chk("sim_data2", sample_data_o, 0);
      chk("sim_no_ovr", overrun_o, 0);

      // Stop mid-window, ratio 6
      do_reset();
      pat = 4'b1111;
      sample_ready_i = 1'b1;
      do_start(16'd6);
      repeat (3) step();
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      chk("stop_busy", busy_o, 1);
      chk("stop_gate_run", gate_rst_o, 0);
      wait_valid(20, cyc);
      chk("stop_lat", cyc, 3);
      chk("stop_data", sample_data_o, 6);
      chk("stop_gate", gate_rst_o, 1);
      chk("stop_acc", acc_rst_o, 1);
      chk("stop_idle", busy_o, 0);
      repeat (10) step();
      chk("stop_no_more", sample_valid_o, 0);
      chk("stop_gate_held", gate_rst_o, 1);

      // Reset at wcnt=3 of the second window, then a clean restart
      do_reset();
      pat = 4'b1111;
      sample_ready_i = 1'b0;
      do_start(16'd5);
      wait_valid(20, cyc);
      chk("mr_data1", sample_data_o, 5);
      repeat (4) step();
      reset = 1'b1;
      #1;
      chk("mr_gate", gate_rst_o, 1);
      chk("mr_acc", acc_rst_o, 1);
      chk("mr_valid", sample_valid_o, 0);
      chk("mr_data", sample_data_o, 0);
      chk("mr_busy", busy_o, 0);
      chk("mr_ovr", overrun_o, 0);
      step();
      reset = 1'b0;
      sample_ready_i = 1'b1;
      step();
      do_start(16'd5);
      wait_valid(20, cyc);
      chk("mr_lat", cyc, 6);
      chk("mr_data2", sample_data_o, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
